tx_payload_sched: RTL and testbench
===================================

// Module: tx_payload_sched
// PURPOSE
//  Payload scheduler in front of tx_sdh_framer (STM-4, 4 byte-interleaved AU-4s).
//  Turns the framer's one-cycle-early sdh_tx_din_req into round-robin reads from four
//  first-word-fall-through tributary FIFOs and drives sdh_tx_din.
//  Inserts a fill byte on empty or disabled channels.
//  Keeps per-channel underflow statistics and per-frame sticky flags.
// PARAMETERS
//  NUM_CH    4      tributary count; fixed at 4, must match framer interleave
//  FILL_BYTE 8'hFF  byte sent when a slot cannot be served
//  UF_W      16     width of each saturating underflow counter
// PORTS
//  sdh_clk         in   1        byte clock shared with framer
//  rst_n           in   1        asynchronous, active-low reset
//  sdh_tx_din_req  in   1        framer payload request; data is consumed the cycle after
//  start_of_frame  in   1        framer frame pulse (row 0, col 0, mu 0)
//  ch_en           in   4        per-channel enable (quasi-static config)
//  ch_empty        in   4        FIFO empty, one bit per channel
//  ch_data         in   32       FWFT head bytes, channel i = [8i+7:8i]
//  ch_rd           out  4        FIFO read strobe, one-hot or zero
//  sdh_tx_din      out  8        payload byte to framer
//  uf_clr          in   1        synchronous clear of all underflow counters
//  uf_cnt          out  4*UF_W   saturating underflow counts, channel i at [UF_W*i +: UF_W]
//  uf_frame        out  4        per-channel underflow seen in the previous complete frame
// BEHAVIOUR
//  Reset values: slot=0, req_d=0, ch_rd=0, sdh_tx_din=FILL_BYTE, uf_cnt=0, uf_frame=0, uf_acc=0.
//  Slot counter (2b):
//   - Rising edge of req (req & !req_d) forces the current slot to 0.
//   - Slot then increments mod 4 every cycle that req=1.
//   - First payload byte of each row is therefore always channel 0.
//  Serving a request cycle t (req=1, slot=s):
//   - Service is possible when ch_en[s] & !ch_empty[s].
//   - ch_rd[s] = req & ch_en[s] & !ch_empty[s]; this is combinational in cycle t.
//   - sdh_tx_din <= ch_data[s] when served, else FILL_BYTE. The register is valid at t+1.
//  Latency: exactly 1 sdh_clk from req to sdh_tx_din. This matches the framer sampling
//   sdh_tx_din from col 9.
//  req=0: ch_rd=0 and sdh_tx_din <= FILL_BYTE. Section overhead never reads a FIFO.
//  Underflow = req & ch_en[s] & ch_empty[s]. A disabled channel never counts as underflow.
//  uf_cnt[s]:
//   - +1 on underflow, saturating at 2^UF_W-1 (no wrap).
//   - uf_clr has priority: the counter loads 1 if underflow occurs in the same cycle, else 0.
//  uf_acc (4b):
//   - Bit s is set on underflow.
//   - On start_of_frame: uf_frame <= uf_acc | current-cycle underflow bits, and uf_acc <= 0.
//  ch_en change mid-row takes effect on the next slot; no realignment occurs.
//  Row/frame shape (270 col x 9 row x 4) is entirely framer-owned; this block has no column logic.
//  Reset asserted mid-row: all state clears asynchronously.
//   - Realignment happens at the next req rising edge.
//   - Any read in flight is lost, and the FIFO side must tolerate this.
// STRUCTURE
//  Shared package sdh_tx_pkg: SDH_NUM_AU4=4, SDH_FILL_BYTE, SDH_UF_W, slot typedef (2b).
//  One sub-module, tx_sched_uf_cnt: a saturating counter with clear/inc/sat.
//   - Instantiated 4 times via generate.
//  Top level holds the slot counter, req edge detect, read decode, data mux/register and
//   the frame-flag accumulator.
// TESTING
//  1. All 4 FIFOs non-empty with ch_data=8'h10+i and one 261*4-cycle req burst.
//     -> ch_rd order 0,1,2,3 repeating.
//     -> sdh_tx_din = 10,11,12,13... starting 1 cycle after req rises.
//     -> 261 reads per channel per row.
//  2. ch_empty[2]=1 for a full frame.
//     -> Every 4th byte (slot 2) = 8'hFF.
//     -> uf_cnt[2] = 9*261 = 2349.
//     -> uf_frame = 4'b0100 after the next start_of_frame.
//  3. ch_en=4'b1011 with FIFO 2 empty.
//     -> Slot-2 bytes = FILL_BYTE.
//     -> ch_rd[2] never asserted; uf_cnt[2] stays 0.
//  4. Preload uf_cnt[0] to 16'hFFFE, then 3 underflows.
//     -> Counter holds at 16'hFFFF.
//     -> uf_clr coincident with an underflow -> 16'h0001.
//  5. Assert rst_n low mid-row at slot 3, release, restart req.
//     -> ch_rd=0 and sdh_tx_din=8'hFF during reset.
//     -> First read after release is channel 0.
//  6. Underflow on the same cycle as start_of_frame.
//     -> The event appears in uf_frame.
//     -> uf_acc is clean for the new frame.

Source files
------------

// File: rtl/sdh_tx_pkg.sv
// Shared constants and types for the SDH transmit payload path.
// The STM-4 interleave is fixed at four AU-4s and must agree with the framer.
package sdh_tx_pkg;

    localparam int          SDH_NUM_AU4   = 4;
    localparam logic [7:0]  SDH_FILL_BYTE = 8'hFF;
    localparam int          SDH_UF_W      = 16;

    typedef logic [1:0] slot_t;

    // Slots wrap naturally because the type is exactly two bits wide.
    function automatic slot_t slot_next(input slot_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/tx_sched_uf_cnt.sv
// Saturating event counter with a synchronous clear.
// A clear that coincides with an event keeps that event, so the count restarts at one.
module tx_sched_uf_cnt #(
    parameter int W = 16
) (
    input  logic         sdh_clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {{(W-1){1'b0}}, inc_i};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge sdh_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_payload_sched.sv
// Round-robin payload scheduler between four FWFT tributary FIFOs and the STM-4 framer.
// Each request slot reads one channel; empty or disabled channels are replaced by a fill byte.
module tx_payload_sched
    import sdh_tx_pkg::*;
#(
    parameter int         NUM_CH    = SDH_NUM_AU4,
    parameter logic [7:0] FILL_BYTE = SDH_FILL_BYTE,
    parameter int         UF_W      = SDH_UF_W
) (
    input  logic                   sdh_clk,
    input  logic                   rst_n,
    input  logic                   sdh_tx_din_req,
    input  logic                   start_of_frame,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [NUM_CH-1:0]      ch_empty,
    input  logic [8*NUM_CH-1:0]    ch_data,
    output logic [NUM_CH-1:0]      ch_rd,
    output logic [7:0]             sdh_tx_din,
    input  logic                   uf_clr,
    output logic [NUM_CH*UF_W-1:0] uf_cnt,
    output logic [NUM_CH-1:0]      uf_frame
);

    logic              req_q;
    slot_t             slot_q, slot_d;
    slot_t             cur_slot;
    logic [7:0]        din_q, din_d;
    logic [NUM_CH-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [NUM_CH-1:0] rd_vec;
    logic [NUM_CH-1:0] uf_vec;
    logic [7:0]        head_byte;

    // A request rising edge marks the first payload byte of a row, always channel 0.
    always_comb begin
        cur_slot = (sdh_tx_din_req && !req_q) ? slot_t'(0) : slot_q;
        slot_d   = slot_q;
        if (sdh_tx_din_req) begin
            slot_d = slot_next(cur_slot);
        end
    end

    always_comb begin
        rd_vec = '0;
        uf_vec = '0;
        if (sdh_tx_din_req && ch_en[cur_slot]) begin
            if (ch_empty[cur_slot]) begin
                uf_vec[cur_slot] = 1'b1;
            end else begin
                rd_vec[cur_slot] = 1'b1;
            end
        end
    end

    assign head_byte = ch_data[{cur_slot, 3'b000} +: 8];

    always_comb begin
        din_d   = (|rd_vec) ? head_byte : FILL_BYTE;
        acc_d   = acc_q | uf_vec;
        frame_d = frame_q;
        // Underflows in the frame-pulse cycle belong to the frame that is closing.
        if (start_of_frame) begin
            frame_d = acc_q | uf_vec;
            acc_d   = '0;
        end
    end

    always_ff @(posedge sdh_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            slot_q  <= '0;
            din_q   <= FILL_BYTE;
            acc_q   <= '0;
            frame_q <= '0;
        end else begin
            req_q   <= sdh_tx_din_req;
            slot_q  <= slot_d;
            din_q   <= din_d;
            acc_q   <= acc_d;
            frame_q <= frame_d;
        end
    end

    // The read strobe is combinational, so it is gated to keep the FIFOs untouched in reset.
    assign ch_rd      = rd_vec & {NUM_CH{rst_n}};
    assign sdh_tx_din = din_q;
    assign uf_frame   = frame_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_uf
        tx_sched_uf_cnt #(
            .W(UF_W)
        ) u_uf_cnt (
            .sdh_clk(sdh_clk),
            .rst_n  (rst_n),
            .clr_i  (uf_clr),
            .inc_i  (uf_vec[g]),
            .cnt_o  (uf_cnt[UF_W*g +: UF_W])
        );
    end

endmodule

// File: tb/tb_tx_payload_sched.sv
// Bench for tx_payload_sched: behavioural per-cycle model plus directed literal checks.
// Counter width is reduced so saturation is reachable in a short run.
module tb_tx_payload_sched;

    localparam int UF_W   = 12;
    localparam int UF_MAX = (1 << UF_W) - 1;

    logic            sdh_clk;
    logic            rst_n;
    logic            req;
    logic            sof;
    logic [3:0]      ch_en;
    logic [3:0]      ch_empty;
    logic [31:0]     ch_data;
    logic [3:0]      ch_rd;
    logic [7:0]      sdh_tx_din;
    logic            uf_clr;
    logic [4*UF_W-1:0] uf_cnt;
    logic [3:0]      uf_frame;

    tx_payload_sched #(
        .UF_W(UF_W)
    ) dut (
        .sdh_clk       (sdh_clk),
        .rst_n         (rst_n),
        .sdh_tx_din_req(req),
        .start_of_frame(sof),
        .ch_en         (ch_en),
        .ch_empty      (ch_empty),
        .ch_data       (ch_data),
        .ch_rd         (ch_rd),
        .sdh_tx_din    (sdh_tx_din),
        .uf_clr        (uf_clr),
        .uf_cnt        (uf_cnt),
        .uf_frame      (uf_frame)
    );

    // clock
    initial begin
        sdh_clk = 1'b0;
        forever #5 sdh_clk = ~sdh_clk;
    end

    int n_vec;
    int n_err;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model state
    int   m_run;
    bit   m_req_prev;
    int   m_din;
    int   m_cnt[4];
    bit [3:0] m_acc;
    bit [3:0] m_frame;
    int   rd_count[4];
    bit   want_first;
    int   first_rd;

    // Compare process: registered outputs reflect the previous cycle, ch_rd the current one.
    always @(negedge sdh_clk) begin
        int s;
        bit [3:0] exp_rd;
        bit [3:0] u;
        if (!rst_n) begin
            chk("rst_ch_rd", int'(ch_rd), 0);
            chk("rst_din", int'(sdh_tx_din), 8'hFF);
            chk("rst_uf_cnt", int'(uf_cnt != '0), 0);
            chk("rst_uf_frame", int'(uf_frame), 0);
            m_run = 0;
            m_req_prev = 1'b0;
            m_din = 8'hFF;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_acc = '0;
            m_frame = '0;
        end else begin
            chk("din", int'(sdh_tx_din), m_din);
            chk("uf_frame", int'(uf_frame), int'(m_frame));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("uf_cnt%0d", i), int'(uf_cnt[UF_W*i +: UF_W]), m_cnt[i]);
            end
            // slot is the position of this cycle within the current request run
            if (req && !m_req_prev) m_run = 0;
            s = m_run % 4;
            if (req) m_run++;
            exp_rd = '0;
            u = '0;
            if (req && ch_en[s]) begin
                if (ch_empty[s]) u[s] = 1'b1;
                else exp_rd[s] = 1'b1;
            end
            chk("ch_rd", int'(ch_rd), int'(exp_rd));
            m_din = (exp_rd != 0) ? int'(ch_data[8*s +: 8]) : 8'hFF;
            for (int i = 0; i < 4; i++) begin
                if (uf_clr) m_cnt[i] = int'(u[i]);
                else if (u[i] && m_cnt[i] < UF_MAX) m_cnt[i]++;
                rd_count[i] += int'(ch_rd[i]);
            end
            if (sof) begin
                m_frame = m_acc | u;
                m_acc = '0;
            end else begin
                m_acc = m_acc | u;
            end
            m_req_prev = req;
            if (want_first && ch_rd != 0) begin
                first_rd = int'(ch_rd);
                want_first = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sdh_clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) rd_count[i] = 0;
    endtask

    task automatic pulse_clr();
        uf_clr = 1'b1;
        step(1);
        uf_clr = 1'b0;
    endtask

    // One framer row: 9 overhead columns x 4 then 261 payload columns x 4.
    task automatic row(input bit with_sof);
        req = 1'b0;
        sof = with_sof;
        step(1);
        sof = 1'b0;
        step(35);
        req = 1'b1;
        step(1044);
        req = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        want_first = 1'b0;
        first_rd = 0;
        clr_counts();
        rst_n = 1'b0;
        req = 1'b0;
        sof = 1'b0;
        ch_en = 4'hF;
        ch_empty = 4'h0;
        ch_data = 32'h13121110;
        uf_clr = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        // 1: one full row, all channels served in order
        clr_counts();
        step(36);
        req = 1'b1;
        step(1);
        chk("t1_first_byte", int'(sdh_tx_din), 8'h10);
        step(1);
        chk("t1_second_byte", int'(sdh_tx_din), 8'h11);
        step(1042);
        req = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_reads%0d", i), rd_count[i], 261);

        // 2: channel 2 empty for a whole frame
        pulse_clr();
        ch_empty = 4'b0100;
        for (int r = 0; r < 9; r++) row(r == 0);
        ch_empty = 4'b0000;
        chk("t2_uf_cnt2", int'(uf_cnt[UF_W*2 +: UF_W]), 2349);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        chk("t2_uf_frame", int'(uf_frame), 4'b0100);

        // 3: channel 2 disabled and empty
        pulse_clr();
        clr_counts();
        ch_en = 4'b1011;
        ch_empty = 4'b0100;
        row(1'b0);
        step(2);
        chk("t3_reads2", rd_count[2], 0);
        chk("t3_uf_cnt2", int'(uf_cnt[UF_W*2 +: UF_W]), 0);
        chk("t3_reads0", rd_count[0], 261);
        ch_en = 4'hF;
        ch_empty = 4'h0;

        // 4: saturation, then clear coincident with underflow
        pulse_clr();
        ch_en = 4'b0001;
        ch_empty = 4'b1111;
        for (int k = 0; k < UF_MAX - 1; k++) begin
            req = 1'b1;
            step(1);
            req = 1'b0;
            step(1);
        end
        chk("t4_preload", int'(uf_cnt[0 +: UF_W]), UF_MAX - 1);
        for (int k = 0; k < 3; k++) begin
            req = 1'b1;
            step(1);
            req = 1'b0;
            step(1);
        end
        chk("t4_saturated", int'(uf_cnt[0 +: UF_W]), UF_MAX);
        req = 1'b1;
        uf_clr = 1'b1;
        step(1);
        req = 1'b0;
        uf_clr = 1'b0;
        chk("t4_clr_with_uf", int'(uf_cnt[0 +: UF_W]), 1);
        ch_en = 4'hF;
        ch_empty = 4'h0;
        step(2);

        // 5: reset asserted mid-row at slot 3, request held through reset
        req = 1'b1;
        step(7);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        want_first = 1'b1;
        step(3);
        req = 1'b0;
        step(2);
        chk("t5_first_rd", first_rd, 4'b0001);

        // 6: underflow in the frame-pulse cycle
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        step(3);
        ch_empty = 4'b0001;
        req = 1'b1;
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        ch_empty = 4'b0000;
        chk("t6_uf_frame", int'(uf_frame), 4'b0001);
        step(20);
        req = 1'b0;
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        chk("t6_acc_clean", int'(uf_frame), 4'b0000);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) req = ~req;
            if ($urandom_range(0, 99) == 0) ch_en = 4'($urandom_range(0, 15));
            ch_empty = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            ch_data = $urandom;
            sof = ($urandom_range(0, 299) == 0);
            uf_clr = ($urandom_range(0, 199) == 0);
            step(1);
        end
        req = 1'b0;
        sof = 1'b0;
        uf_clr = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
